// File: rtl/lsu_stbuf_queue.sv
// Store buffer: in-order FIFO of committed store words feeding the DCCM/PIC port.
// Define RV_LSU_STBUF_FWD_EN to build the DC2->DC3 store-to-load forwarding path.
module lsu_stbuf_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int ECC_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stq_wr_en,
  input  logic [ADDR_W-1:0]         stq_wr_addr,
  input  logic                      stq_wr_in_pic,
  input  logic [DATA_W-1:0]         stq_wr_data,
  input  logic [ECC_W-1:0]          stq_wr_ecc,
  input  logic [DATA_W/8-1:0]       stq_wr_byteen,
  output logic                      stbuf_reqvld_any,
  output logic [ADDR_W-1:0]         stbuf_addr_any,
  output logic                      stbuf_addr_in_pic_any,
  output logic [DATA_W-1:0]         stbuf_data_any,
  output logic [ECC_W-1:0]          stbuf_ecc_any,
  input  logic                      lsu_stbuf_commit_any,
  output logic                      stbuf_full,
  output logic                      stbuf_empty,
  output logic [$clog2(DEPTH):0]    stbuf_count,
  output logic                      stbuf_overflow,
  input  logic                      fwd_en_dc2,
  input  logic [ADDR_W-1:0]         fwd_addr_lo_dc2,
  input  logic [ADDR_W-1:0]         fwd_addr_hi_dc2,
  output logic [DATA_W-1:0]         stbuf_fwddata_lo_dc3,
  output logic [DATA_W-1:0]         stbuf_fwddata_hi_dc3,
  output logic [DATA_W/8-1:0]       stbuf_fwdbyteen_lo_dc3,
  output logic [DATA_W/8-1:0]       stbuf_fwdbyteen_hi_dc3
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DATA_W / 8;

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  ent_vld;
  logic [DEPTH-1:0]  ent_pic;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [ECC_W-1:0]  ent_ecc  [DEPTH];
  logic [BW-1:0]     ent_be   [DEPTH];

  logic wr_ok;
  logic rd_ok;

  // A full queue can still accept when the head drains this cycle
  assign wr_ok = stq_wr_en &
                 ((count < CW'(DEPTH)) | lsu_stbuf_commit_any);
  assign rd_ok = lsu_stbuf_commit_any & (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      ent_vld        <= '0;
      stbuf_overflow <= 1'b0;
    end else begin
      if (rd_ok) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      // Set after clear: full with enq+deq reuses the head slot
      if (wr_ok) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end else if (stq_wr_en) begin
        stbuf_overflow <= 1'b1;
      end
      if (wr_ok && !rd_ok)
        count <= count + CW'(1);
      else if (rd_ok && !wr_ok)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ent_addr[wr_ptr] <= stq_wr_addr;
      ent_pic[wr_ptr]  <= stq_wr_in_pic;
      ent_data[wr_ptr] <= stq_wr_data;
      ent_ecc[wr_ptr]  <= stq_wr_ecc;
      ent_be[wr_ptr]   <= stq_wr_byteen;
    end
  end

  assign stbuf_empty           = (count == '0);
  assign stbuf_full            = (count == CW'(DEPTH));
  assign stbuf_count           = count;
  assign stbuf_reqvld_any      = ~stbuf_empty;
  assign stbuf_addr_any        = stbuf_empty ? '0 : ent_addr[rd_ptr];
  assign stbuf_addr_in_pic_any = ~stbuf_empty & ent_pic[rd_ptr];
  assign stbuf_data_any        = stbuf_empty ? '0 : ent_data[rd_ptr];
  assign stbuf_ecc_any         = stbuf_empty ? '0 : ent_ecc[rd_ptr];

`ifdef RV_LSU_STBUF_FWD_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BW-1:0]     be;
  } fwd_t;

  fwd_t fwd_lo;
  fwd_t fwd_hi;

  // Walk oldest to youngest so younger bytes overwrite older ones
  function automatic fwd_t lookup(input logic [ADDR_W-1:0] a);
    fwd_t          r;
    logic [PW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (ent_vld[idx] && !ent_pic[idx] &&
          ent_addr[idx][ADDR_W-1:2] == a[ADDR_W-1:2]) begin
        for (int b = 0; b < BW; b++) begin
          if (ent_be[idx][b]) begin
            r.data[8*b +: 8] = ent_data[idx][8*b +: 8];
            r.be[b]          = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    fwd_lo = lookup(fwd_addr_lo_dc2);
    fwd_hi = lookup(fwd_addr_hi_dc2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stbuf_fwddata_lo_dc3   <= '0;
      stbuf_fwddata_hi_dc3   <= '0;
      stbuf_fwdbyteen_lo_dc3 <= '0;
      stbuf_fwdbyteen_hi_dc3 <= '0;
    end else if (fwd_en_dc2) begin
      stbuf_fwddata_lo_dc3   <= fwd_lo.data;
      stbuf_fwddata_hi_dc3   <= fwd_hi.data;
      stbuf_fwdbyteen_lo_dc3 <= fwd_lo.be;
      stbuf_fwdbyteen_hi_dc3 <= fwd_hi.be;
    end
  end

  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr_lo_dc2[1:0], fwd_addr_hi_dc2[1:0]};
`else
  assign stbuf_fwddata_lo_dc3   = '0;
  assign stbuf_fwddata_hi_dc3   = '0;
  assign stbuf_fwdbyteen_lo_dc3 = '0;
  assign stbuf_fwdbyteen_hi_dc3 = '0;

  logic unused_fwd;
  assign unused_fwd = ^{fwd_en_dc2, fwd_addr_lo_dc2, fwd_addr_hi_dc2,
                        ent_vld, stq_wr_byteen};
  logic [BW-1:0] unused_be;
  always_comb begin
    unused_be = '0;
    for (int i = 0; i < DEPTH; i++) unused_be = unused_be ^ ent_be[i];
  end
`endif

endmodule
